// File: rtl/pulse_meas_ctrl.sv
// Pulse measurement controller: shared timebase, per-channel period/width capture
// with timeout, and in-order readout of masked channel results over a valid/ready port.
module pulse_meas_ctrl #(
  parameter int unsigned NCH      = 4,
  parameter logic [31:0] TIMEOUT  = 32'd1000000,
  parameter int unsigned PIPE_LAT = 3,
  localparam int unsigned CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [NCH-1:0]    edge_in,
  input  logic [32*NCH-1:0] period_in,
  input  logic [32*NCH-1:0] width_in,
  output logic [31:0]       count,
  output logic              pulse_full,
  output logic [NCH-1:0]    meas_ena,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_chan,
  output logic [31:0]       out_period,
  output logic [31:0]       out_width,
  output logic              out_timeout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEAS, S_READ, S_DONE} state_t;

  state_t          state;
  logic [NCH-1:0]  mask_q;
  logic [1:0]      edge_cnt    [NCH];
  logic [LW-1:0]   lat_cnt     [NCH];
  logic [31:0]     to_cnt      [NCH];
  logic [31:0]     hold_period [NCH];
  logic [31:0]     hold_width  [NCH];
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  ch_done;
  logic [NCH-1:0]  ch_to;

  logic            all_done_c;
  logic            next_found_c;
  logic [CW-1:0]   first_idx_c;
  logic [CW-1:0]   next_idx_c;

  // Free-running timebase; the wrap flag lands on the cycle count reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      pulse_full <= 1'b0;
    end else begin
      pulse_full <= ena && (count == 32'hFFFF_FFFF);
      if (ena) count <= count + 32'd1;
    end
  end

  // Per-channel edge counting, result capture after the pipeline latency, and timeout.
  // A second edge commits the channel to capture and stops its timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        edge_cnt[i]    <= '0;
        lat_cnt[i]     <= '0;
        to_cnt[i]      <= '0;
        hold_period[i] <= '0;
        hold_width[i]  <= '0;
      end
      pend    <= '0;
      ch_done <= '0;
      ch_to   <= '0;
    end else if (!ena || state == S_ARM) begin
      for (int i = 0; i < int'(NCH); i++) begin
        edge_cnt[i] <= '0;
        lat_cnt[i]  <= '0;
        to_cnt[i]   <= '0;
      end
      pend    <= '0;
      ch_done <= '0;
      ch_to   <= '0;
    end else if (state == S_MEAS) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (mask_q[i] && !ch_done[i]) begin
          if (edge_in[i] && edge_cnt[i] != 2'd2) edge_cnt[i] <= edge_cnt[i] + 2'd1;
          if (edge_in[i] && edge_cnt[i] == 2'd1) begin
            pend[i]    <= 1'b1;
            lat_cnt[i] <= LAT_INIT;
          end else if (pend[i]) begin
            if (lat_cnt[i] == '0) begin
              hold_period[i] <= period_in[32*i +: 32];
              hold_width[i]  <= width_in[32*i +: 32];
              ch_done[i]     <= 1'b1;
              ch_to[i]       <= 1'b0;
            end else begin
              lat_cnt[i] <= lat_cnt[i] - LW'(1);
            end
          end else if (to_cnt[i] == TIMEOUT - 32'd1) begin
            hold_period[i] <= '0;
            hold_width[i]  <= '0;
            ch_done[i]     <= 1'b1;
            ch_to[i]       <= 1'b1;
          end else begin
            to_cnt[i] <= to_cnt[i] + 32'd1;
          end
        end
      end
    end
  end

  // Lowest masked channel, and lowest masked channel above the one being presented
  always_comb begin
    all_done_c   = &(ch_done | ~mask_q);
    first_idx_c  = '0;
    next_idx_c   = '0;
    next_found_c = 1'b0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_idx_c = CW'(i);
        if (i > int'(out_chan)) begin
          next_idx_c   = CW'(i);
          next_found_c = 1'b1;
        end
      end
    end
  end

  // Controller FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      meas_ena    <= '0;
      out_valid   <= 1'b0;
      out_chan    <= '0;
      out_period  <= '0;
      out_width   <= '0;
      out_timeout <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!ena && state != S_IDLE) begin
        state     <= S_IDLE;
        meas_ena  <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && ena) begin
              mask_q <= chan_mask;
              state  <= S_ARM;
              busy   <= 1'b1;
            end
          end
          S_ARM: begin
            if (mask_q == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_MEAS;
              meas_ena <= mask_q;
            end
          end
          S_MEAS: begin
            if (all_done_c) begin
              state       <= S_READ;
              meas_ena    <= '0;
              out_valid   <= 1'b1;
              out_chan    <= first_idx_c;
              out_period  <= hold_period[first_idx_c];
              out_width   <= hold_width[first_idx_c];
              out_timeout <= ch_to[first_idx_c];
            end
          end
          S_READ: begin
            if (out_ready) begin
              if (next_found_c) begin
                out_chan    <= next_idx_c;
                out_period  <= hold_period[next_idx_c];
                out_width   <= hold_width[next_idx_c];
                out_timeout <= ch_to[next_idx_c];
              end else begin
                out_valid <= 1'b0;
                state     <= S_DONE;
                done      <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_meas_ctrl.sv
// Self-checking bench for pulse_meas_ctrl: directed scenarios plus randomized edge
// schedules checked against a per-channel outcome model.
module tb_pulse_meas_ctrl;

  localparam int unsigned NCH      = 4;
  localparam logic [31:0] TIMEOUT  = 32'd50;
  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned CW       = 2;
  localparam int          LIMIT    = int'(TIMEOUT) + int'(PIPE_LAT) + 20;

  logic              clk = 1'b0;
  logic              rst, ena, start, out_ready;
  logic [NCH-1:0]    chan_mask, edge_in, meas_ena;
  logic [32*NCH-1:0] period_in, width_in;
  logic [31:0]       count, out_period, out_width;
  logic              pulse_full, out_valid, out_timeout, busy, done;
  logic [CW-1:0]     out_chan;

  int checks   = 0;
  int failures = 0;

  // Edge schedule per channel, in cycles relative to the first MEAS cycle (-1 = none)
  int          e1 [NCH];
  int          e2 [NCH];
  int          e3 [NCH];
  logic [31:0] pv [NCH];
  logic [31:0] wv [NCH];

  pulse_meas_ctrl #(.NCH(NCH), .TIMEOUT(TIMEOUT), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .chan_mask(chan_mask),
    .edge_in(edge_in), .period_in(period_in), .width_in(width_in),
    .count(count), .pulse_full(pulse_full), .meas_ena(meas_ena),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_period(out_period), .out_width(out_width), .out_timeout(out_timeout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Captured iff the second edge arrives no later than the last cycle before timeout
  function automatic bit captured(input int i);
    return (e1[i] >= 0) && (e2[i] > e1[i]) && (e2[i] <= int'(TIMEOUT) - 1);
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < int'(NCH); i++) begin
      e1[i] = -1; e2[i] = -1; e3[i] = -1;
      pv[i] = $urandom; wv[i] = $urandom;
    end
  endtask

  task automatic gen_random();
    clear_sched();
    for (int i = 0; i < int'(NCH); i++) begin
      case ($urandom_range(0, 4))
        0: ;
        1: e1[i] = int'($urandom_range(0, 60));
        2: begin e1[i] = int'($urandom_range(0, 48)); e2[i] = int'(TIMEOUT) - 1; end
        3: begin e1[i] = int'(TIMEOUT) - 1; e2[i] = int'(TIMEOUT) + 2; end
        default: begin
          e1[i] = int'($urandom_range(0, 30));
          e2[i] = e1[i] + int'($urandom_range(1, 25));
        end
      endcase
      if (e2[i] >= 0 && $urandom_range(0, 1) == 1) e3[i] = e2[i] + int'($urandom_range(1, 5));
    end
  endtask

  // Result slice is correct only in the cycle PIPE_LAT after the second edge
  task automatic drive_k(input int k);
    for (int i = 0; i < int'(NCH); i++) begin
      edge_in[i] = (k == e1[i]) || (k == e2[i]) || (k == e3[i]);
      period_in[32*i +: 32] = (e2[i] >= 0 && k == e2[i] + int'(PIPE_LAT)) ? pv[i] : ~pv[i];
      width_in[32*i +: 32]  = (e2[i] >= 0 && k == e2[i] + int'(PIPE_LAT)) ? wv[i] : ~wv[i];
    end
  endtask

  task automatic launch(input logic [NCH-1:0] m, input bit poke, output bit seen);
    int kmin;
    int t;
    kmin = 0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (m[i]) begin
        t = captured(i) ? e2[i] + int'(PIPE_LAT) + 1 : int'(TIMEOUT);
        if (t > kmin) kmin = t;
      end
    end
    chk1("idle_busy", busy, 1'b0);
    start = 1'b1; chan_mask = m;
    @(negedge clk);
    start = 1'b0; chan_mask = NCH'($urandom);
    chk1("arm_busy", busy, 1'b1);
    chk1("arm_valid", out_valid, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < LIMIT && !seen; k++) begin
      @(negedge clk);
      if (k == 0) chk32("meas_ena", 32'(meas_ena), 32'(m));
      if (out_valid) begin
        seen = 1'b1;
        chk1("valid_latency", k >= kmin, 1'b1);
      end else begin
        drive_k(k);
        start = poke && (k == 3);
        if (start) chan_mask = ~m;
      end
    end
    start = 1'b0; edge_in = '0;
    chk1("valid_seen", seen, 1'b1);
    if (seen) chk32("read_meas_ena", 32'(meas_ena), 32'd0);
  endtask

  task automatic chk_payload(input int i);
    bit cap;
    cap = captured(i);
    chk1("out_valid", out_valid, 1'b1);
    chk32("out_chan", 32'(out_chan), 32'(i));
    chk32("out_period", out_period, cap ? pv[i] : 32'd0);
    chk32("out_width", out_width, cap ? wv[i] : 32'd0);
    chk1("out_timeout", out_timeout, !cap);
  endtask

  task automatic read_out(input logic [NCH-1:0] m, input int stall0);
    int st;
    int j;
    j = 0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (m[i]) begin
        st = (stall0 >= 0) ? ((j == 0) ? stall0 : 0) : int'($urandom_range(0, 2));
        out_ready = 1'b0;
        chk_payload(i);
        repeat (st) begin
          @(negedge clk);
          chk_payload(i);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        j++;
      end
    end
    chk1("done_pulse", done, 1'b1);
    chk1("done_valid_low", out_valid, 1'b0);
    @(negedge clk);
    chk1("done_clear", done, 1'b0);
    chk1("idle_after_done", busy, 1'b0);
  endtask

  task automatic zero_mask();
    chk1("zm_idle", busy, 1'b0);
    start = 1'b1; chan_mask = '0;
    @(negedge clk);
    chan_mask = '1;
    chk1("zm_arm_busy", busy, 1'b1);
    chk1("zm_arm_done", done, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk1("zm_done", done, 1'b1);
    chk1("zm_valid", out_valid, 1'b0);
    chk1("zm_done_busy", busy, 1'b1);
    @(negedge clk);
    chk1("zm_done_clear", done, 1'b0);
    chk1("zm_idle_busy", busy, 1'b0);
    @(negedge clk);
    chk1("zm_start_ignored", busy, 1'b0);
  endtask

  initial begin
    bit seen;
    bit dseen;
    logic [NCH-1:0] m;

    rst = 1'b1; ena = 1'b0; start = 1'b0; out_ready = 1'b0;
    chan_mask = '0; edge_in = '0; period_in = '0; width_in = '0;
    clear_sched();
    repeat (2) @(negedge clk);
    chk32("rst_count", count, 32'd0);
    chk1("rst_pulse_full", pulse_full, 1'b0);
    chk32("rst_meas_ena", 32'(meas_ena), 32'd0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_chan", 32'(out_chan), 32'd0);
    chk32("rst_out_period", out_period, 32'd0);
    chk32("rst_out_width", out_width, 32'd0);
    chk1("rst_out_timeout", out_timeout, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);

    // Timebase: run, hold, then wrap from a preloaded value
    rst = 1'b0; ena = 1'b1;
    repeat (5) @(negedge clk);
    chk32("count_run", count, 32'd5);
    chk1("no_wrap_after_reset", pulse_full, 1'b0);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    chk32("count_hold", count, 32'd5);
    ena = 1'b1;
    force dut.count = 32'hFFFF_FFFD;
    #1;
    release dut.count;
    @(negedge clk);
    chk32("wrap_m2", count, 32'hFFFF_FFFE);
    chk1("wrap_m2_pf", pulse_full, 1'b0);
    @(negedge clk);
    chk32("wrap_m1", count, 32'hFFFF_FFFF);
    chk1("wrap_m1_pf", pulse_full, 1'b0);
    @(negedge clk);
    chk32("wrap_0", count, 32'd0);
    chk1("wrap_0_pf", pulse_full, 1'b1);
    @(negedge clk);
    chk32("wrap_1", count, 32'd1);
    chk1("wrap_1_pf", pulse_full, 1'b0);

    // Two channels captured, ascending readout
    clear_sched();
    pv[0] = 32'd1000; wv[0] = 32'd400; e1[0] = 2; e2[0] = 6;
    pv[2] = 32'd2500; wv[2] = 32'd900; e1[2] = 1; e2[2] = 4;
    e1[1] = 0; e2[1] = 3;
    launch(4'b0101, 1'b0, seen);
    if (seen) read_out(4'b0101, 0);

    // Single channel, no edges: timeout result
    clear_sched();
    launch(4'b0010, 1'b0, seen);
    if (seen) read_out(4'b0010, 0);

    // All channels, first result stalled 10 cycles
    clear_sched();
    e1[0] = 0; e2[0] = 5;  e1[1] = 3; e2[1] = 9;
    e1[2] = 7; e2[2] = 12; e1[3] = 1; e2[3] = 2; e3[3] = 4;
    launch(4'b1111, 1'b0, seen);
    if (seen) read_out(4'b1111, 10);

    zero_mask();

    // Abort by dropping ena during MEAS
    clear_sched();
    e1[0] = 2; e2[0] = 30; e1[1] = 4; e2[1] = 40;
    start = 1'b1; chan_mask = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    chk1("abort_arm_busy", busy, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      drive_k(k);
    end
    ena = 1'b0;
    @(negedge clk);
    chk32("abort_meas_ena", 32'(meas_ena), 32'd0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_valid", out_valid, 1'b0);
    chk1("abort_done", done, 1'b0);
    ena = 1'b1; edge_in = '0;
    dseen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || out_valid || busy) dseen = 1'b1;
    end
    chk1("abort_quiet", dseen, 1'b0);
    gen_random();
    launch(4'b0011, 1'b0, seen);
    if (seen) read_out(4'b0011, -1);

    // Asynchronous reset during READ
    clear_sched();
    e1[2] = 0; e2[2] = 5; e1[3] = 3; e2[3] = 8;
    launch(4'b1100, 1'b0, seen);
    if (seen) begin
      rst = 1'b1;
      #1;
      chk1("rstread_valid", out_valid, 1'b0);
      chk1("rstread_busy", busy, 1'b0);
      chk32("rstread_meas_ena", 32'(meas_ena), 32'd0);
      chk32("rstread_chan", 32'(out_chan), 32'd0);
      chk32("rstread_period", out_period, 32'd0);
      chk1("rstread_done", done, 1'b0);
      chk32("rstread_count", count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
    end
    gen_random();
    launch(4'b1001, 1'b0, seen);
    if (seen) read_out(4'b1001, -1);

    // Randomized runs
    for (int it = 0; it < 10; it++) begin
      m = NCH'($urandom);
      gen_random();
      if (m == '0) zero_mask();
      else begin
        launch(m, 1'($urandom), seen);
        if (seen) read_out(m, -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
